// File: rtl/cmd_sequencer.sv
// Command sequencer: queues 16-bit command words and plays them one at a time to
// RemoteComm, checking each response byte for a positive ack, with timeout and abort handling.
module cmd_sequencer #(
  parameter int          DEPTH        = 8,
  parameter logic [21:0] TIMEOUT_CLKS = 22'd4000000,
  parameter logic [7:0]  POS_ACK      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [15:0]            push_cmd,
  input  logic                   start,
  input  logic                   abort,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [7:0]             n_acked
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT_CLKS > 22'd1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 22'd1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NACK  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SNT,
    WAIT_RESP,
    CHECK
  } state_t;

  state_t state_reg, state_next;

  // Command queue storage and pointers
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;
  logic          flush;

  // Control / status registers
  logic [15:0]   cmd_reg;
  logic          snd_cmd_reg;
  logic          done_reg;
  logic          err_reg;
  logic [1:0]    err_code_reg;
  logic [7:0]    n_acked_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [7:0]    resp_reg;
  logic          abort_pend_reg;

  // Next-state decode outputs
  logic          abort_pend_next;
  logic          abort_now;
  logic          err_set;
  logic [1:0]    err_code_set;
  logic          clr_stats;
  logic          ack_inc;
  logic          done_next;
  logic          tmo_clr;
  logic          tmo_inc;
  logic          resp_load;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = (state_reg == LOAD) && !empty;
  // A push into a full queue only fits if the head leaves in the same cycle
  assign do_push = push && !flush && (!full || do_pop);

  assign cmd      = cmd_reg;
  assign snd_cmd  = snd_cmd_reg;
  assign count    = count_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;
  assign n_acked  = n_acked_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    state_next      = state_reg;
    flush           = 1'b0;
    err_set         = 1'b0;
    err_code_set    = ERR_NONE;
    clr_stats       = 1'b0;
    ack_inc         = 1'b0;
    done_next       = 1'b0;
    abort_pend_next = abort_pend_reg;
    tmo_clr         = 1'b0;
    tmo_inc         = 1'b0;
    resp_load       = 1'b0;
    abort_now       = abort || abort_pend_reg;

    case (state_reg)
      IDLE: begin
        abort_pend_next = 1'b0;
        if (abort) begin
          flush = 1'b1;
        end else if (start) begin
          clr_stats = 1'b1;
          if (!empty) begin
            state_next = LOAD;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      LOAD: begin
        if (abort) begin
          abort_pend_next = 1'b1;
        end
        state_next = WAIT_SNT;
      end

      WAIT_SNT: begin
        if (abort) begin
          abort_pend_next = 1'b1;
        end
        if (cmd_snt) begin
          tmo_clr = 1'b1;
          if (abort_now) begin
            state_next      = IDLE;
            flush           = 1'b1;
            err_set         = 1'b1;
            err_code_set    = ERR_ABORT;
            abort_pend_next = 1'b0;
          end else begin
            state_next = WAIT_RESP;
          end
        end
      end

      WAIT_RESP: begin
        if (abort) begin
          abort_pend_next = 1'b1;
        end
        tmo_inc = 1'b1;
        // A response on the final count still wins over the timeout
        if (resp_rdy) begin
          resp_load = 1'b1;
          if (abort_now) begin
            ack_inc         = (resp == POS_ACK);
            state_next      = IDLE;
            flush           = 1'b1;
            err_set         = 1'b1;
            err_code_set    = ERR_ABORT;
            abort_pend_next = 1'b0;
          end else begin
            state_next = CHECK;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = IDLE;
          err_set    = 1'b1;
          if (abort_now) begin
            flush           = 1'b1;
            err_code_set    = ERR_ABORT;
            abort_pend_next = 1'b0;
          end else begin
            err_code_set = ERR_TMO;
          end
        end
      end

      CHECK: begin
        if (abort) begin
          abort_pend_next = 1'b1;
        end
        if (resp_reg == POS_ACK) begin
          ack_inc = 1'b1;
          if (!empty) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          state_next   = IDLE;
          err_set      = 1'b1;
          err_code_set = ERR_NACK;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cmd_reg        <= 16'h0000;
      snd_cmd_reg    <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      n_acked_reg    <= 8'd0;
      tmo_cnt_reg    <= '0;
      resp_reg       <= 8'd0;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      snd_cmd_reg    <= (state_next == LOAD);
      done_reg       <= done_next;
      abort_pend_reg <= abort_pend_next;

      // Capture the head on entry so cmd is already valid while snd_cmd is high
      if (state_next == LOAD) begin
        cmd_reg <= mem[rd_ptr_reg];
      end

      if (clr_stats) begin
        err_reg      <= 1'b0;
        err_code_reg <= ERR_NONE;
        n_acked_reg  <= 8'd0;
      end else begin
        if (err_set) begin
          err_reg      <= 1'b1;
          err_code_reg <= err_code_set;
        end
        if (ack_inc && (n_acked_reg != 8'hFF)) begin
          n_acked_reg <= n_acked_reg + 8'd1;
        end
      end

      if (tmo_clr) begin
        tmo_cnt_reg <= '0;
      end else if (tmo_inc && (tmo_cnt_reg != TMO_LAST)) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end

      if (resp_load) begin
        resp_reg <= resp;
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: drain, wrap, timeout, nack, abort and reset scenarios
// with hand-derived expectations and a short timeout so the timeout path is cheap to reach.
module tb_cmd_sequencer;

  localparam int          DEPTH = 8;
  localparam int          T     = 64;
  localparam logic [21:0] TMO   = 22'd64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [15:0] push_cmd = 16'h0000;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  n_acked;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] snd_log [$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  cmd_sequencer #(
    .DEPTH(DEPTH),
    .TIMEOUT_CLKS(TMO),
    .POS_ACK(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_cmd(push_cmd),
    .start(start),
    .abort(abort),
    .cmd(cmd),
    .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy),
    .resp(resp),
    .full(full),
    .empty(empty),
    .count(count),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .n_acked(n_acked)
  );

  always @(negedge clk) begin
    if (snd_cmd) begin
      snd_log.push_back(cmd);
      $display("[%0t] txn snd_cmd cmd=%h", $time, cmd);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      $display("[%0t] txn done n_acked=%0d", $time, n_acked);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] v);
    push     = 1'b1;
    push_cmd = v;
    tick();
    push     = 1'b0;
    $display("[%0t] txn push %h count=%0d", $time, v, count);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_snd(input string tag);
    int k;
    k = 0;
    while (!snd_cmd && k < 200) begin
      tick();
      k++;
    end
    check_eq({tag, "_snd_seen"}, 32'(snd_cmd), 32'd1);
  endtask

  task automatic respond(input int snt_dly, input int resp_dly, input logic [7:0] r);
    repeat (snt_dly) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (resp_dly - 1) tick();
    resp     = r;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    $display("[%0t] txn resp %h", $time, r);
  endtask

  task automatic serve(input string tag, input int snt_dly, input int resp_dly, input logic [7:0] r);
    wait_snd(tag);
    respond(snt_dly, resp_dly, r);
  endtask

  initial begin
    int base;
    int dbase;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_cmd", 32'(cmd), 32'd0);
    check_eq("rst_snd", 32'(snd_cmd), 32'd0);

    // Two-command drain with positive acks
    base  = snd_log.size();
    dbase = done_cnt;
    push_one(16'h2FF0);
    push_one(16'h4004);
    pulse_start();
    serve("t1a", 10, 50, 8'hA5);
    serve("t1b", 10, 50, 8'hA5);
    repeat (3) tick();
    check_eq("t1_nsnd", 32'(snd_log.size() - base), 32'd2);
    check_eq("t1_cmd0", 32'(snd_log[base]), 32'h2FF0);
    check_eq("t1_cmd1", 32'(snd_log[base+1]), 32'h4004);
    check_eq("t1_done", 32'(done_cnt - dbase), 32'd1);
    check_eq("t1_nack", 32'(n_acked), 32'd2);
    check_eq("t1_err", 32'(err), 32'd0);
    check_eq("t1_cmd_hold", 32'(cmd), 32'h4004);

    // Fill past capacity across the pointer wrap, then push+pop while full
    base  = snd_log.size();
    dbase = done_cnt;
    for (int i = 0; i < 8; i++) push_one(16'h1000 + 16'(i));
    check_eq("t2_full", 32'(full), 32'd1);
    check_eq("t2_count8", 32'(count), 32'd8);
    push_one(16'h1DDD);
    check_eq("t2_drop_count", 32'(count), 32'd8);
    pulse_start();
    push     = 1'b1;
    push_cmd = 16'h1008;
    tick();
    push     = 1'b0;
    check_eq("t2_pushpop_count", 32'(count), 32'd8);
    check_eq("t2_pushpop_full", 32'(full), 32'd1);
    respond(0, 3, 8'hA5);
    for (int i = 1; i < 9; i++) serve("t2", 2, 3, 8'hA5);
    repeat (3) tick();
    check_eq("t2_nsnd", 32'(snd_log.size() - base), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("t2_order%0d", i), 32'(snd_log[base+i]), 32'h1000 + 32'(i));
    end
    check_eq("t2_nack", 32'(n_acked), 32'd9);
    check_eq("t2_done", 32'(done_cnt - dbase), 32'd1);
    check_eq("t2_empty", 32'(empty), 32'd1);

    // Timeout with no response
    dbase = done_cnt;
    push_one(16'h4004);
    pulse_start();
    wait_snd("t3");
    repeat (3) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (T - 1) tick();
    check_eq("t3_err_early", 32'(err), 32'd0);
    check_eq("t3_busy_early", 32'(busy), 32'd1);
    tick();
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_code", 32'(err_code), 32'd2);
    check_eq("t3_busy", 32'(busy), 32'd0);
    resp     = 8'hA5;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    tick();
    check_eq("t3_late_resp", 32'(n_acked), 32'd0);
    check_eq("t3_done", 32'(done_cnt - dbase), 32'd0);

    // Response on the very last timeout count wins; start clears the sticky error
    dbase = done_cnt;
    push_one(16'h1234);
    pulse_start();
    check_eq("t4_err_clr", 32'(err), 32'd0);
    check_eq("t4_code_clr", 32'(err_code), 32'd0);
    serve("t4", 2, T, 8'hA5);
    repeat (2) tick();
    check_eq("t4_err", 32'(err), 32'd0);
    check_eq("t4_nack", 32'(n_acked), 32'd1);
    check_eq("t4_done", 32'(done_cnt - dbase), 32'd1);

    // Bad ack on the second of three
    base  = snd_log.size();
    dbase = done_cnt;
    push_one(16'h00A1);
    push_one(16'h00A2);
    push_one(16'h00A3);
    pulse_start();
    serve("t5a", 2, 5, 8'hA5);
    serve("t5b", 2, 5, 8'h5A);
    repeat (20) tick();
    check_eq("t5_code", 32'(err_code), 32'd1);
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_nack", 32'(n_acked), 32'd1);
    check_eq("t5_count", 32'(count), 32'd1);
    check_eq("t5_nsnd", 32'(snd_log.size() - base), 32'd2);
    check_eq("t5_busy", 32'(busy), 32'd0);

    // Abort in IDLE flushes without touching the error state
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t6_idle_flush", 32'(empty), 32'd1);
    check_eq("t6_idle_code", 32'(err_code), 32'd1);

    // Abort during WAIT_RESP, then a positive ack with a coincident push
    base  = snd_log.size();
    dbase = done_cnt;
    push_one(16'h00B1);
    push_one(16'h00B2);
    push_one(16'h00B3);
    pulse_start();
    wait_snd("t6");
    repeat (2) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    resp     = 8'hA5;
    resp_rdy = 1'b1;
    push     = 1'b1;
    push_cmd = 16'hBEEF;
    tick();
    resp_rdy = 1'b0;
    push     = 1'b0;
    check_eq("t6_nack", 32'(n_acked), 32'd1);
    check_eq("t6_empty", 32'(empty), 32'd1);
    check_eq("t6_code", 32'(err_code), 32'd3);
    check_eq("t6_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check_eq("t6_nsnd", 32'(snd_log.size() - base), 32'd1);
    check_eq("t6_done", 32'(done_cnt - dbase), 32'd0);

    // Reset mid-WAIT_RESP with two entries still queued
    push_one(16'h00C1);
    push_one(16'h00C2);
    push_one(16'h00C3);
    push_one(16'h00C4);
    pulse_start();
    serve("t7a", 2, 3, 8'hA5);
    wait_snd("t7b");
    repeat (2) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (5) tick();
    check_eq("t7_pre_count", 32'(count), 32'd2);
    check_eq("t7_pre_nack", 32'(n_acked), 32'd1);
    rst      = 1'b1;
    push     = 1'b1;
    push_cmd = 16'hDEAD;
    tick();
    rst  = 1'b0;
    push = 1'b0;
    check_eq("t7_count", 32'(count), 32'd0);
    check_eq("t7_empty", 32'(empty), 32'd1);
    check_eq("t7_full", 32'(full), 32'd0);
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_done", 32'(done), 32'd0);
    check_eq("t7_err", 32'(err), 32'd0);
    check_eq("t7_code", 32'(err_code), 32'd0);
    check_eq("t7_nack", 32'(n_acked), 32'd0);
    check_eq("t7_cmd", 32'(cmd), 32'd0);
    check_eq("t7_snd", 32'(snd_cmd), 32'd0);
    resp     = 8'hA5;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    tick();
    check_eq("t7_late_nack", 32'(n_acked), 32'd0);
    check_eq("t7_late_busy", 32'(busy), 32'd0);

    // Start with an empty queue: done pulses next cycle, FSM stays idle
    pulse_start();
    check_eq("t8_done", 32'(done), 32'd1);
    check_eq("t8_busy", 32'(busy), 32'd0);
    tick();
    check_eq("t8_done_off", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning command queue depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 22'd4000000, meaning max clocks allowed in WAIT_RESP before timeout.
REQ-003 SHALL have parameter POS_ACK, default 8'hA5, meaning response byte counted as success.
REQ-004 SHALL have the following ports, with one clock and a synchronous, active-high reset:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  enqueue push_cmd this cycle.
- push_cmd  input  16  move/calibrate command word.
- start  input  1  single-cycle pulse; begin draining the queue.
- abort  input  1  stop after the current response or timeout; flush the queue.
- cmd  output  16  command word presented to RemoteComm.
- snd_cmd  output  1  single-cycle send strobe to RemoteComm.
- cmd_snt  input  1  RemoteComm finished transmitting the command.
- resp_rdy  input  1  response byte valid (one-cycle pulse).
- resp  input  8  response byte from the DUT.
- full, empty  output  1 each  queue status.
- count  output  $clog2(DEPTH)+1  entries queued.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse when the queue drains with every ack positive.
- err  output  1  sticky error flag; cleared by start or rst.
- err_code  output  2  00 none, 01 bad ack, 10 timeout, 11 aborted.
- n_acked  output  8  commands positively acknowledged since last start; saturates at 255.

Function
REQ-005 Queue SHALL be a circular FIFO with wrap-around read and write pointers.
REQ-006 Push while full SHALL be ignored; count, contents and pointers SHALL be unchanged.
REQ-007 Push and pop in the same cycle SHALL leave count unchanged, including when full.
REQ-008 FSM states SHALL be IDLE, LOAD, WAIT_SNT, WAIT_RESP, CHECK.
REQ-009 IDLE: start while !empty -> LOAD. Start while empty -> done pulses the next cycle and the FSM stays in IDLE.
REQ-010 LOAD: cmd <= queue head; snd_cmd = 1 for exactly this one cycle; head popped; -> WAIT_SNT.
REQ-011 cmd SHALL hold its value from LOAD until the next LOAD.
REQ-012 WAIT_SNT: cmd_snt -> WAIT_RESP, and the timeout counter clears to 0.
REQ-013 WAIT_RESP: counter increments every clock; resp_rdy -> CHECK with resp latched.
REQ-014 WAIT_RESP timeout: when counter == TIMEOUT_CLKS-1 without resp_rdy -> IDLE with err=1, err_code=10.
REQ-015 If resp_rdy arrives in the same cycle the counter hits its limit, the response SHALL win (no timeout).
REQ-016 CHECK, resp==POS_ACK: n_acked++ (saturating). Then -> LOAD if !empty, else -> IDLE with a done pulse.
REQ-017 CHECK, resp!=POS_ACK: -> IDLE with err=1, err_code=01, and remaining queue entries retained.
REQ-018 Exactly one response SHALL be accepted per command; resp_rdy outside WAIT_RESP SHALL be ignored.
REQ-019 cmd_snt outside WAIT_SNT SHALL be ignored.
REQ-020 abort in WAIT_SNT or WAIT_RESP SHALL take effect only when that state would otherwise exit. Result: queue flushed, -> IDLE, err=1, err_code=11.
REQ-021 abort in IDLE SHALL flush the queue without setting err.
REQ-022 abort in LOAD or CHECK SHALL be remembered and applied at the next exit from WAIT_SNT or WAIT_RESP.
REQ-023 A push that coincides with the abort flush SHALL be dropped.
REQ-024 push SHALL be accepted in every state, so the queue can be refilled while the FSM runs.
REQ-025 start while busy SHALL be ignored.
REQ-026 start from IDLE SHALL clear err, err_code and n_acked.
REQ-027 The timeout counter SHALL be wide enough for TIMEOUT_CLKS and SHALL NOT wrap.

Reset
REQ-028 rst SHALL force, on the next rising edge: state=IDLE, pointers=0, count=0, empty=1, full=0, cmd=16'h0000, snd_cmd=0, busy=0, done=0, err=0, err_code=00, n_acked=0, timeout counter=0.
REQ-029 rst SHALL override every other input in the same cycle and SHALL abandon any in-flight command.
REQ-030 There SHALL be no outputs driven by an asynchronous path from rst.

Verification
REQ-031 Push 16'h2FF0 then 16'h4004, pulse start; model cmd_snt after 10 clks and resp=A5 after 50 clks, each time. Required: two snd_cmd pulses with cmd=2FF0 then 4004, one done pulse, n_acked=2, err=0.
REQ-032 Push 9 entries with DEPTH=8. Required: full=1 after 8 pushes, count=8, 9th dropped; drained order matches push order across pointer wrap.
REQ-033 Push 16'h4004, start, send cmd_snt, send no response. Required: err=1 and err_code=10 exactly TIMEOUT_CLKS clocks after cmd_snt; busy=0; no done pulse.
REQ-034 Push 3 commands, start; respond A5 to the first and 5A to the second. Required: err_code=01, n_acked=1, count=1, no third snd_cmd.
REQ-035 Push 3 commands, start, assert abort during WAIT_RESP of the first, then deliver A5. Required: n_acked=1, empty=1, err_code=11, busy=0.
REQ-036 Assert rst mid-WAIT_RESP with 2 entries queued. Required: every REQ-028 value holds next cycle, and a later resp_rdy is ignored.
